call_rtn_stack: RTL and testbench

Hardware return-address stack for the 8-bit RISC core. It is the counterpart of the program counter's return-address load path. On a CALL in WRITEBACK, the sequencer pushes the return address (PC+1) into this block. On a RET, it pops the stack, and the program counter loads Return_Addr on the same clock edge. The block also provides full/empty status and sticky overflow/underflow error flags to the control unit.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/stack_regfile.sv | 27 ++
 rtl/call_rtn_stack.sv | 119 +++++++++++
 tb/tb_call_rtn_stack.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the return-stack operation decode
package cpu_pkg;

    localparam int CPU_ADDR_W  = 8;
    localparam int STACK_DEPTH = 8;

    // Opcodes the sequencer decodes into Push_Call / Pop_Rtn
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;

    typedef enum logic [1:0] {
        SOP_IDLE,
        SOP_PUSH,
        SOP_POP,
        SOP_REPLACE
    } stack_op_e;

    function automatic stack_op_e decode_stack_op(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return SOP_PUSH;
            2'b01:   return SOP_POP;
            2'b11:   return SOP_REPLACE;
            default: return SOP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - return-stack entry array, one sync write port, one comb read port
module stack_regfile
    import cpu_pkg::*;
#(
    parameter int DEPTH  = STACK_DEPTH,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_rtn_stack.sv
// rtl/call_rtn_stack.sv - return-address stack with registered top-of-stack and sticky error flags
module call_rtn_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int CNT_W  = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Push_Call,
    input  logic              Pop_Rtn,
    input  logic [ADDR_W-1:0] Push_Addr,
    input  logic              Clr_Err,
    output logic [ADDR_W-1:0] Return_Addr,
    output logic              Stack_Empty,
    output logic              Stack_Full,
    output logic              Stack_Ovf,
    output logic              Stack_Unf,
    output logic [CNT_W-1:0]  Count
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count_q, count_nxt, cnt_m1, cnt_m2;
    logic [ADDR_W-1:0] top_q, top_nxt;
    logic              ovf_q, unf_q, ovf_set, unf_set;
    logic              empty, full;
    logic              rf_we;
    logic [IDX_W-1:0]  rf_waddr, rf_raddr;
    logic [ADDR_W-1:0] rf_rdata;
    stack_op_e         op;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign cnt_m1 = count_q - CNT_W'(1);
    assign cnt_m2 = count_q - CNT_W'(2);

    always_comb begin
        op        = decode_stack_op(Push_Call, Pop_Rtn);
        rf_we     = 1'b0;
        rf_waddr  = count_q[IDX_W-1:0];
        rf_raddr  = cnt_m2[IDX_W-1:0];
        count_nxt = count_q;
        top_nxt   = top_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (op)
            SOP_PUSH: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    rf_we     = 1'b1;
                    count_nxt = count_q + CNT_W'(1);
                    top_nxt   = Push_Addr;
                end
            end
            SOP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else if (count_q == CNT_W'(1)) begin
                    count_nxt = '0;
                    top_nxt   = '0;
                end else begin
                    count_nxt = cnt_m1;
                    top_nxt   = rf_rdata;
                end
            end
            SOP_REPLACE: begin
                // On an empty stack the pop half underflows but the push still lands
                rf_we   = 1'b1;
                top_nxt = Push_Addr;
                if (empty) begin
                    unf_set   = 1'b1;
                    count_nxt = CNT_W'(1);
                end else begin
                    rf_waddr = cnt_m1[IDX_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            top_q   <= top_nxt;
            ovf_q   <= ovf_set | (ovf_q & ~Clr_Err);
            unf_q   <= unf_set | (unf_q & ~Clr_Err);
        end
    end

    stack_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .Clk   (Clk),
        .we    (rf_we & ~Reset),
        .waddr (rf_waddr),
        .wdata (Push_Addr),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    assign Return_Addr = top_q;
    assign Count       = count_q;
    assign Stack_Empty = empty;
    assign Stack_Full  = full;
    assign Stack_Ovf   = ovf_q;
    assign Stack_Unf   = unf_q;

endmodule

// File: tb/tb_call_rtn_stack.sv
// tb/tb_call_rtn_stack.sv - directed and random checks of call_rtn_stack against a queue model
module tb_call_rtn_stack;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 5;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Push_Call = 1'b0;
    logic              Pop_Rtn = 1'b0;
    logic [ADDR_W-1:0] Push_Addr = '0;
    logic              Clr_Err = 1'b0;
    logic [ADDR_W-1:0] Return_Addr;
    logic              Stack_Empty, Stack_Full, Stack_Ovf, Stack_Unf;
    logic [CNT_W-1:0]  Count;

    int tests  = 0;
    int errors = 0;

    logic [ADDR_W-1:0] q[$];
    bit                m_ovf, m_unf;

    call_rtn_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Push_Call   (Push_Call),
        .Pop_Rtn     (Pop_Rtn),
        .Push_Addr   (Push_Addr),
        .Clr_Err     (Clr_Err),
        .Return_Addr (Return_Addr),
        .Stack_Empty (Stack_Empty),
        .Stack_Full  (Stack_Full),
        .Stack_Ovf   (Stack_Ovf),
        .Stack_Unf   (Stack_Unf),
        .Count       (Count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [CNT_W+ADDR_W+3:0] model_vec();
        logic [ADDR_W-1:0] top;
        top = (q.size() != 0) ? q[q.size()-1] : '0;
        return {CNT_W'(q.size()), top, q.size() == 0, q.size() == DEPTH, m_ovf, m_unf};
    endfunction

    function automatic logic [CNT_W+ADDR_W+3:0] dut_vec();
        return {Count, Return_Addr, Stack_Empty, Stack_Full, Stack_Ovf, Stack_Unf};
    endfunction

    // One clock of stimulus; the model is advanced by the stack rules, not by the RTL
    task automatic step(input bit push, input bit pop, input logic [ADDR_W-1:0] addr,
                        input bit clr, input bit rst);
        bit so, su;
        Push_Call = push; Pop_Rtn = pop; Push_Addr = addr; Clr_Err = clr; Reset = rst;
        @(posedge Clk);
        #1;
        so = 0; su = 0;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_unf = 0;
        end else begin
            if (push && pop) begin
                if (q.size() == 0) begin q.push_back(addr); su = 1; end
                else q[q.size()-1] = addr;
            end else if (push) begin
                if (q.size() == DEPTH) so = 1;
                else q.push_back(addr);
            end else if (pop) begin
                if (q.size() == 0) su = 1;
                else void'(q.pop_back());
            end
            m_ovf = so | (m_ovf & !clr);
            m_unf = su | (m_unf & !clr);
        end
        Push_Call = 0; Pop_Rtn = 0; Clr_Err = 0; Reset = 0;
    endtask

    task automatic test_reset();
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        tests++;
        if (Count !== 5'd0 || Return_Addr !== 8'h00 || Stack_Empty !== 1'b1 ||
            Stack_Full !== 1'b0 || Stack_Ovf !== 1'b0 || Stack_Unf !== 1'b0)
            begin errors++; $display("FAIL reset: got %h expected %h", dut_vec(), {5'd0, 8'h00, 4'b1000}); end
    endtask

    task automatic test_push_pop();
        logic [ADDR_W-1:0] exp_ra [3];
        exp_ra = '{8'h22, 8'h11, 8'h00};
        step(0, 0, 8'h00, 0, 1);
        step(1, 0, 8'h11, 0, 0);
        step(1, 0, 8'h22, 0, 0);
        step(1, 0, 8'h33, 0, 0);
        tests++;
        if (Count !== 5'd3 || Return_Addr !== 8'h33 || Stack_Empty !== 1'b0)
            begin errors++; $display("FAIL push3: count=%0d ra=%h empty=%b expected 3 33 0", Count, Return_Addr, Stack_Empty); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h00, 0, 0);
            tests++;
            if (Return_Addr !== exp_ra[i])
                begin errors++; $display("FAIL pop_seq[%0d]: ra=%h expected %h", i, Return_Addr, exp_ra[i]); end
        end
        tests++;
        if (Stack_Empty !== 1'b1 || Stack_Ovf !== 1'b0 || Stack_Unf !== 1'b0)
            begin errors++; $display("FAIL pop_end: empty=%b ovf=%b unf=%b expected 1 0 0", Stack_Empty, Stack_Ovf, Stack_Unf); end
    endtask

    task automatic test_overflow();
        step(0, 0, 8'h00, 0, 1);
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 8'(i), 0, 0);
        tests++;
        if (Stack_Full !== 1'b1 || Return_Addr !== 8'h08 || Stack_Ovf !== 1'b0)
            begin errors++; $display("FAIL fill: full=%b ra=%h ovf=%b expected 1 08 0", Stack_Full, Return_Addr, Stack_Ovf); end
        step(1, 0, 8'hAA, 0, 0);
        tests++;
        if (Stack_Ovf !== 1'b1 || Count !== 5'd8 || Return_Addr !== 8'h08)
            begin errors++; $display("FAIL ovf: ovf=%b count=%0d ra=%h expected 1 8 08", Stack_Ovf, Count, Return_Addr); end
        for (int k = 1; k <= DEPTH; k++) begin
            step(0, 1, 8'h00, 0, 0);
            tests++;
            if (Return_Addr !== 8'(DEPTH - k))
                begin errors++; $display("FAIL ovf_drain[%0d]: ra=%h expected %h", k, Return_Addr, 8'(DEPTH - k)); end
        end
    endtask

    task automatic test_underflow_clr();
        step(0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h00, 0, 0);
        tests++;
        if (Stack_Unf !== 1'b1 || Count !== 5'd0 || Return_Addr !== 8'h00)
            begin errors++; $display("FAIL unf: unf=%b count=%0d ra=%h expected 1 0 00", Stack_Unf, Count, Return_Addr); end
        step(0, 0, 8'h00, 1, 0);
        tests++;
        if (Stack_Unf !== 1'b0)
            begin errors++; $display("FAIL clr_err: unf=%b expected 0", Stack_Unf); end
        step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 1, 0);
        tests++;
        if (Stack_Unf !== 1'b1)
            begin errors++; $display("FAIL set_beats_clr: unf=%b expected 1", Stack_Unf); end
    endtask

    task automatic test_replace();
        step(0, 0, 8'h00, 0, 1);
        step(1, 0, 8'h40, 0, 0);
        step(1, 0, 8'h41, 0, 0);
        step(1, 1, 8'h5A, 0, 0);
        tests++;
        if (Count !== 5'd2 || Return_Addr !== 8'h5A || Stack_Ovf !== 1'b0 || Stack_Unf !== 1'b0)
            begin errors++; $display("FAIL replace: count=%0d ra=%h expected 2 5a", Count, Return_Addr); end
        step(0, 1, 8'h00, 0, 0);
        tests++;
        if (Return_Addr !== 8'h40)
            begin errors++; $display("FAIL replace_pop: ra=%h expected 40", Return_Addr); end
        step(0, 0, 8'h00, 0, 1);
        step(1, 1, 8'h77, 0, 0);
        tests++;
        if (Count !== 5'd1 || Return_Addr !== 8'h77 || Stack_Unf !== 1'b1)
            begin errors++; $display("FAIL replace_empty: count=%0d ra=%h unf=%b expected 1 77 1", Count, Return_Addr, Stack_Unf); end
        for (int i = 1; i < DEPTH; i++) step(1, 0, 8'(8'h80 + i), 0, 0);
        step(1, 1, 8'hC3, 1, 0);
        tests++;
        if (Count !== 5'd8 || Return_Addr !== 8'hC3 || Stack_Ovf !== 1'b0 || Stack_Full !== 1'b1)
            begin errors++; $display("FAIL replace_full: count=%0d ra=%h ovf=%b expected 8 c3 0", Count, Return_Addr, Stack_Ovf); end
    endtask

    task automatic test_pc_integration();
        logic [ADDR_W-1:0] pc, ra_seen;
        step(0, 0, 8'h00, 0, 1);
        pc = 8'h10;
        step(1, 0, pc + 8'h01, 0, 0);
        pc = 8'h30;
        ra_seen = Return_Addr;
        step(0, 1, 8'h00, 0, 0);
        pc = ra_seen;
        tests++;
        if (pc !== 8'h11 || Count !== 5'd0)
            begin errors++; $display("FAIL pc_ret: pc=%h count=%0d expected 11 0", pc, Count); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h00, 0, 0);
        for (int i = 0; i <= DEPTH; i++) step(1, 0, 8'(8'hE0 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0);
        tests++;
        if (Count !== 5'd5 || Stack_Ovf !== 1'b1 || Stack_Unf !== 1'b1 || Return_Addr !== 8'hE4)
            begin errors++; $display("FAIL reset_mid_pre: count=%0d ovf=%b unf=%b ra=%h expected 5 1 1 e4", Count, Stack_Ovf, Stack_Unf, Return_Addr); end
        step(1, 0, 8'hEE, 0, 1);
        tests++;
        if (Count !== 5'd0 || Return_Addr !== 8'h00 || Stack_Ovf !== 1'b0 ||
            Stack_Unf !== 1'b0 || Stack_Empty !== 1'b1)
            begin errors++; $display("FAIL reset_mid: got %h expected %h", dut_vec(), {5'd0, 8'h00, 4'b1000}); end
    endtask

    task automatic test_random();
        bit push, pop, clr, rst;
        int r;
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 800; i++) begin
            r    = $urandom_range(0, 99);
            // Alternate push-heavy and pop-heavy phases so both saturation edges are hit
            if ((i / 60) % 2 == 0) begin push = (r < 65); pop = (r >= 50); end
            else                   begin push = (r < 35); pop = (r >= 20); end
            clr  = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            step(push, pop, 8'($urandom), clr, rst);
            tests++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), model_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow_clr();
        test_replace();
        test_pc_integration();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
